// File: rtl/wb_unit_if.sv
// Write-back stage bus: execution/load sources, register-file write port,
// backpressure, hazard lookup and status.
interface wb_unit_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 4
);
  logic                          exe_valid;
  logic [DATA_WIDTH-1:0]         exe_result;
  logic [REG_ADDR_WIDTH-1:0]     exe_rd;
  logic                          mem_valid;
  logic [DATA_WIDTH-1:0]         mem_data;
  logic [REG_ADDR_WIDTH-1:0]     mem_rd;
  logic                          rf_we;
  logic [REG_ADDR_WIDTH-1:0]     rf_waddr;
  logic [DATA_WIDTH-1:0]         rf_wdata;
  logic                          wb_stall;
  logic [REG_ADDR_WIDTH-1:0]     chk_rd;
  logic                          chk_hit;
  logic                          overflow_err;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    output exe_valid, exe_result, exe_rd, mem_valid, mem_data, mem_rd, chk_rd,
    input  rf_we, rf_waddr, rf_wdata, wb_stall, chk_hit, overflow_err, fifo_count
  );

  modport slave (
    input  exe_valid, exe_result, exe_rd, mem_valid, mem_data, mem_rd, chk_rd,
    output rf_we, rf_waddr, rf_wdata, wb_stall, chk_hit, overflow_err, fifo_count
  );
endinterface

// File: rtl/wb_unit.sv
// Write-back stage: arbitrates load returns and execution results onto the
// single register-file write port, buffering execution results in order.
module wb_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int FIFO_DEPTH     = 4
) (
  input logic       clk,
  input logic       reset,
  wb_unit_if.slave  bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(FIFO_DEPTH - 1);

  logic [DATA_WIDTH-1:0]     q_data [FIFO_DEPTH];
  logic [REG_ADDR_WIDTH-1:0] q_rd   [FIFO_DEPTH];
  logic [PTR_W-1:0]          rd_ptr, wr_ptr;
  logic [CNT_W-1:0]          count, count_nxt;

  logic                      mem_ok, exe_ok, empty;
  logic                      pop, bypass, push_req, push_ok, drop;
  logic                      wr_en;
  logic [REG_ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      hit;

  logic                      rf_we_q, wb_stall_q, overflow_q;
  logic [REG_ADDR_WIDTH-1:0] rf_waddr_q;
  logic [DATA_WIDTH-1:0]     rf_wdata_q;

  // Writes to x0 neither take the port nor enter the buffer.
  always_comb begin
    mem_ok    = bus.mem_valid && (bus.mem_rd != '0);
    exe_ok    = bus.exe_valid && (bus.exe_rd != '0);
    empty     = (count == '0);
    pop       = !mem_ok && !empty;
    bypass    = !mem_ok && empty && exe_ok;
    push_req  = exe_ok && (mem_ok || !empty);
    push_ok   = push_req && ((count != FULL_CNT) || pop);
    drop      = push_req && !push_ok;
    count_nxt = count + CNT_W'(push_ok) - CNT_W'(pop);

    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    if (mem_ok) begin
      wr_en   = 1'b1;
      wr_addr = bus.mem_rd;
      wr_data = bus.mem_data;
    end else if (pop) begin
      wr_en   = 1'b1;
      wr_addr = q_rd[rd_ptr];
      wr_data = q_data[rd_ptr];
    end else if (bypass) begin
      wr_en   = 1'b1;
      wr_addr = bus.exe_rd;
      wr_data = bus.exe_result;
    end
  end

  // Only the `count` entries starting at the head are live.
  always_comb begin
    hit = 1'b0;
    for (int unsigned k = 0; k < FIFO_DEPTH; k++) begin
      if ((CNT_W'(k) < count) && (q_rd[rd_ptr + PTR_W'(k)] == bus.chk_rd) &&
          (bus.chk_rd != '0))
        hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_data[wr_ptr] <= bus.exe_result;
      q_rd[wr_ptr]   <= bus.exe_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      wb_stall_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      count      <= count_nxt;
      wb_stall_q <= (count_nxt >= STALL_CNT);
      if (drop) overflow_q <= 1'b1;
      rf_we_q <= wr_en;
      if (wr_en) begin
        rf_waddr_q <= wr_addr;
        rf_wdata_q <= wr_data;
      end
    end
  end

  assign bus.rf_we        = rf_we_q;
  assign bus.rf_waddr     = rf_waddr_q;
  assign bus.rf_wdata     = rf_wdata_q;
  assign bus.wb_stall     = wb_stall_q;
  assign bus.overflow_err = overflow_q;
  assign bus.fifo_count   = count;
  assign bus.chk_hit      = hit;

endmodule

// File: tb/tb_wb_unit.sv
// Directed vector bench for wb_unit: bypass, collision ordering, fill/overflow,
// x0 discard, hazard lookup and reset mid-operation.
module tb_wb_unit;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int FD = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  wb_unit_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) bus ();

  wb_unit #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic          rst;
    logic          ev;
    logic [DW-1:0] er;
    logic [AW-1:0] ed;
    logic          mv;
    logic [DW-1:0] md;
    logic [AW-1:0] mrd;
    logic [AW-1:0] chk;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          st;
    logic          ov;
    logic [2:0]    cnt;
    logic          hit;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(input logic rst, input logic ev, input logic [DW-1:0] er,
                              input logic [AW-1:0] ed, input logic mv, input logic [DW-1:0] md,
                              input logic [AW-1:0] mrd, input logic [AW-1:0] chk,
                              input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                              input logic st, input logic ov, input logic [2:0] cnt,
                              input logic hit);
    vec_t v;
    v.rst = rst; v.ev = ev; v.er = er; v.ed = ed; v.mv = mv; v.md = md; v.mrd = mrd;
    v.chk = chk; v.we = we; v.wa = wa; v.wd = wd; v.st = st; v.ov = ov; v.cnt = cnt;
    v.hit = hit;
    return v;
  endfunction

  task automatic cmp(input string nm, input int idx, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", nm, idx, act, exp);
    end
  endtask

  task automatic check_outputs(input int idx, input vec_t v);
    n_vec++;
    cmp("rf_we", idx, DW'(bus.rf_we), DW'(v.we));
    if (v.we || v.rst) begin
      cmp("rf_waddr", idx, DW'(bus.rf_waddr), DW'(v.wa));
      cmp("rf_wdata", idx, bus.rf_wdata, v.wd);
    end
    cmp("wb_stall", idx, DW'(bus.wb_stall), DW'(v.st));
    cmp("overflow_err", idx, DW'(bus.overflow_err), DW'(v.ov));
    cmp("fifo_count", idx, DW'(bus.fifo_count), DW'(v.cnt));
    cmp("chk_hit", idx, DW'(bus.chk_hit), DW'(v.hit));
  endtask

  task automatic apply(input int idx, input vec_t v);
    @(negedge clk);
    reset          = v.rst;
    bus.exe_valid  = v.ev;
    bus.exe_result = v.er;
    bus.exe_rd     = v.ed;
    bus.mem_valid  = v.mv;
    bus.mem_data   = v.md;
    bus.mem_rd     = v.mrd;
    bus.chk_rd     = v.chk;
    @(posedge clk);
    #1;
    check_outputs(idx, v);
  endtask

  task automatic chk_only(input int idx, input logic [AW-1:0] rd, input logic exp_hit);
    bus.chk_rd = rd;
    #1;
    n_vec++;
    cmp("chk_hit_sweep", idx, DW'(bus.chk_hit), DW'(exp_hit));
  endtask

  initial begin
    bus.exe_valid = 1'b0; bus.exe_result = '0; bus.exe_rd = '0;
    bus.mem_valid = 1'b0; bus.mem_data = '0; bus.mem_rd = '0; bus.chk_rd = '0;

    //          rst ev  er     ed  mv  md     mrd chk  we wa  wd     st ov cnt hit
    tbl.push_back(mk(1, 0, 'h00, 0,  0, 'h00, 0,  0,   0, 0,  'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'hAA, 5,  0, 'h00, 0,  0,   1, 5,  'hAA, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  0,   0, 0,  'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h22, 4,  1, 'h11, 3,  4,   1, 3,  'h11, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 'h33, 6,  0, 'h00, 0,  4,   1, 4,  'h22, 0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  6,   1, 6,  'h33, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h44, 2,  1, 'hFF, 0,  2,   1, 2,  'h44, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  0,   0, 0,  'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h55, 0,  0, 'h00, 0,  0,   0, 0,  'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'hE7, 7,  1, 'hD0, 1,  7,   1, 1,  'hD0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 1, 'hE8, 8,  1, 'hD1, 1,  0,   1, 1,  'hD1, 0, 0, 2, 0));
    tbl.push_back(mk(0, 1, 'hE9, 9,  1, 'hD2, 1,  0,   1, 1,  'hD2, 1, 0, 3, 0));
    tbl.push_back(mk(0, 1, 'hEA, 10, 1, 'hD3, 1,  0,   1, 1,  'hD3, 1, 0, 4, 0));
    tbl.push_back(mk(0, 1, 'hEB, 11, 1, 'hD4, 1,  9,   1, 1,  'hD4, 1, 1, 4, 1));
    tbl.push_back(mk(0, 1, 'hEC, 12, 1, 'hD5, 1,  12,  1, 1,  'hD5, 1, 1, 4, 0));
    tbl.push_back(mk(0, 1, 'hED, 13, 0, 'h00, 0,  13,  1, 7,  'hE7, 1, 1, 4, 1));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  0,   1, 8,  'hE8, 1, 1, 3, 0));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  0,   1, 9,  'hE9, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  0,   1, 10, 'hEA, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  13,  1, 13, 'hED, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 'h00, 0,  0, 'h00, 0,  0,   0, 0,  'h00, 0, 1, 0, 0));

    for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

    // Hazard lookup on a single buffered rd=9, then after it drains.
    apply(100, mk(0, 1, 'h99, 9, 1, 'hA1, 1, 9,  1, 1, 'hA1, 0, 1, 1, 1));
    chk_only(101, 5'd8, 1'b0);
    chk_only(102, 5'd0, 1'b0);
    chk_only(103, 5'd9, 1'b1);
    apply(104, mk(0, 0, 'h00, 0, 0, 'h00, 0, 9,  1, 9, 'h99, 0, 1, 0, 0));

    // Reset mid-operation with three buffered entries and stall raised.
    apply(110, mk(0, 1, 'hC0, 20, 1, 'hB0, 1, 0,  1, 1, 'hB0, 0, 1, 1, 0));
    apply(111, mk(0, 1, 'hC1, 21, 1, 'hB1, 1, 0,  1, 1, 'hB1, 0, 1, 2, 0));
    apply(112, mk(0, 1, 'hC2, 22, 1, 'hB2, 1, 20, 1, 1, 'hB2, 1, 1, 3, 1));
    apply(113, mk(1, 1, 'hC3, 23, 1, 'hB3, 2, 20, 0, 0, 'h00, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      apply(114 + i, mk(0, 0, 'h00, 0, 0, 'h00, 0, 21, 0, 0, 'h00, 0, 0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
